// File: rtl/simple_gmii_pktgen.sv
// GMII-style frame generator: optional preamble/SFD, incrementing payload,
// IEEE 802.3 CRC32 FCS and a programmable inter-packet gap.
module simple_gmii_pktgen #(
    parameter int unsigned len_sz = 16,
    parameter int unsigned cnt_sz = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [len_sz-1:0] len,
    input  logic [7:0]        seed,
    input  logic              en_preamble,
    input  logic [7:0]        ipg_len,
    input  logic              err_en,
    input  logic [len_sz-1:0] err_idx,
    output logic [7:0]        gmii_data,
    output logic              gmii_dv,
    output logic              gmii_er,
    output logic              busy,
    output logic              done,
    output logic [cnt_sz-1:0] frame_cnt
);

    localparam int unsigned CW = (len_sz > 8) ? len_sz : 8;

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_SFD, S_PAY, S_CRC, S_IPG} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [len_sz-1:0] len_q, err_idx_q;
    logic [7:0]        seed_q, ipg_q;
    logic              err_en_q;
    logic [31:0]       crc_q, crc_d;
    logic [7:0]        data_q, data_d;
    logic              dv_q, dv_d, er_q, er_d, busy_q, busy_d, done_q, done_d;
    logic [cnt_sz-1:0] fcnt_q, fcnt_d;

    logic              idle;
    logic [len_sz-1:0] len_e, err_idx_e;
    logic [7:0]        seed_e, pay_byte;
    logic              err_en_e;
    logic [CW-1:0]     ipg_last;
    logic [31:0]       fcs;

    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in ^ {24'h0, b};
        for (int unsigned i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    // The first byte is launched on the accepting edge, so in IDLE the live
    // inputs stand in for the configuration that is being latched.
    assign idle      = (state_q == S_IDLE);
    assign len_e     = idle ? len     : len_q;
    assign seed_e    = idle ? seed    : seed_q;
    assign err_en_e  = idle ? err_en  : err_en_q;
    assign err_idx_e = idle ? err_idx : err_idx_q;
    assign ipg_last  = (ipg_q == 8'h00) ? '0 : CW'(ipg_q) - CW'(1);
    assign fcs       = ~crc_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d = '0;
                    if (en_preamble)       state_d = S_PRE;
                    else if (len != '0)    state_d = S_PAY;
                    else                   state_d = S_CRC;
                end
            end
            S_PRE: begin
                if (cnt_q == CW'(6)) begin
                    state_d = S_SFD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_SFD: begin
                state_d = (len_q != '0) ? S_PAY : S_CRC;
                cnt_d   = '0;
            end
            S_PAY: begin
                if (cnt_q == CW'(len_q) - CW'(1)) begin
                    state_d = S_CRC;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_CRC: begin
                if (cnt_q == CW'(3)) begin
                    state_d = S_IPG;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_IPG: begin
                if (cnt_q == ipg_last) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are computed for the state being entered so they leave the
    // flops aligned with it; the CRC register rests at all-ones outside PAY/CRC.
    assign pay_byte = seed_e + cnt_d[7:0];

    always_comb begin
        data_d = '0;
        dv_d   = 1'b0;
        er_d   = 1'b0;
        done_d = 1'b0;
        crc_d  = '1;
        unique case (state_d)
            S_PRE: begin
                data_d = 8'h55;
                dv_d   = 1'b1;
            end
            S_SFD: begin
                data_d = 8'hD5;
                dv_d   = 1'b1;
            end
            S_PAY: begin
                data_d = pay_byte;
                dv_d   = 1'b1;
                er_d   = err_en_e && (CW'(err_idx_e) == cnt_d);
                crc_d  = crc_byte(crc_q, pay_byte);
            end
            S_CRC: begin
                data_d = fcs[{cnt_d[1:0], 3'b000} +: 8];
                dv_d   = 1'b1;
                crc_d  = crc_q;
            end
            S_IPG: begin
                done_d = (cnt_d == ipg_last);
            end
            default: ;
        endcase
        busy_d = (state_d != S_IDLE);
        fcnt_d = fcnt_q + cnt_sz'(done_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            len_q     <= '0;
            err_idx_q <= '0;
            seed_q    <= '0;
            ipg_q     <= '0;
            err_en_q  <= 1'b0;
            crc_q     <= '1;
            data_q    <= '0;
            dv_q      <= 1'b0;
            er_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            fcnt_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            crc_q   <= crc_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
            er_q    <= er_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fcnt_q  <= fcnt_d;
            if (idle && start) begin
                len_q     <= len;
                err_idx_q <= err_idx;
                seed_q    <= seed;
                ipg_q     <= ipg_len;
                err_en_q  <= err_en;
            end
        end
    end

    assign gmii_data = data_q;
    assign gmii_dv   = dv_q;
    assign gmii_er   = er_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign frame_cnt = fcnt_q;

endmodule

// File: tb/tb_simple_gmii_pktgen.sv
// Randomized self-checking bench for simple_gmii_pktgen against a
// table-driven CRC32 frame model.
module tb_simple_gmii_pktgen;

    localparam int LEN_SZ = 16;
    localparam int CNT_SZ = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [LEN_SZ-1:0] len = '0;
    logic [7:0]        seed = '0;
    logic              en_preamble = 1'b0;
    logic [7:0]        ipg_len = '0;
    logic              err_en = 1'b0;
    logic [LEN_SZ-1:0] err_idx = '0;
    logic [7:0]        gmii_data;
    logic              gmii_dv, gmii_er, busy, done;
    logic [CNT_SZ-1:0] frame_cnt;

    simple_gmii_pktgen #(.len_sz(LEN_SZ), .cnt_sz(CNT_SZ)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .len(len), .seed(seed),
        .en_preamble(en_preamble), .ipg_len(ipg_len), .err_en(err_en), .err_idx(err_idx),
        .gmii_data(gmii_data), .gmii_dv(gmii_dv), .gmii_er(gmii_er),
        .busy(busy), .done(done), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_total = 0;
    int frames_done = 0;
    logic [31:0] crc_tab [256];
    int cap_d[$], exp_d[$];
    bit cap_e[$], exp_e[$];
    int busy_n, gap_n, done_n, done_at, late_dv;
    bit first_busy, timed_out;
    logic [CNT_SZ-1:0] cnt_end;

    function automatic void build_table();
        logic [31:0] c;
        for (int i = 0; i < 256; i++) begin
            c = 32'(i);
            for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tab[i] = c;
        end
    endfunction

    function automatic void model(bit pre, int ln, int sd, bit een, int eidx);
        logic [31:0] crc;
        int b;
        exp_d.delete(); exp_e.delete();
        crc = 32'hFFFFFFFF;
        if (pre) begin
            for (int i = 0; i < 7; i++) begin exp_d.push_back('h55); exp_e.push_back(0); end
            exp_d.push_back('hD5); exp_e.push_back(0);
        end
        for (int k = 0; k < ln; k++) begin
            b = (sd + k) % 256;
            exp_d.push_back(b);
            exp_e.push_back(een && (k == eidx));
            crc = (crc >> 8) ^ crc_tab[(crc ^ 32'(b)) & 32'hFF];
        end
        crc = ~crc;
        for (int i = 0; i < 4; i++) begin
            exp_d.push_back(int'((crc >> (8 * i)) & 32'hFF));
            exp_e.push_back(0);
        end
    endfunction

    function automatic int first_bad();
        int n;
        n = (cap_d.size() > exp_d.size()) ? cap_d.size() : exp_d.size();
        for (int i = 0; i < n; i++) begin
            if (i >= cap_d.size() || i >= exp_d.size()) return i;
            if (cap_d[i] != exp_d[i] || cap_e[i] != exp_e[i]) return i;
        end
        return -1;
    endfunction

    // Requests one frame, records it until busy falls, scrambling the inputs
    // after the accepting edge; hammer keeps start high throughout.
    task automatic run_frame(input bit pre, input int ln, input int sd, input int ipg,
                             input bit een, input int eidx, input bit hammer, input bit hold);
        cap_d.delete(); cap_e.delete();
        busy_n = 0; gap_n = 0; done_n = 0; done_at = -1; late_dv = 0;
        first_busy = 0; timed_out = 1;
        @(negedge clk);
        en_preamble = pre; len = LEN_SZ'(ln); seed = 8'(sd); ipg_len = 8'(ipg);
        err_en = een; err_idx = LEN_SZ'(eidx); start = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            if (c == 0) first_busy = busy;
            if (!busy) begin timed_out = 0; break; end
            busy_n++;
            if (gmii_dv) begin
                cap_d.push_back(int'(gmii_data)); cap_e.push_back(gmii_er);
                if (gap_n > 0) late_dv++;
            end else begin
                gap_n++;
                if (gmii_er || gmii_data != 8'h00) late_dv++;
            end
            if (done) begin done_n++; done_at = busy_n; end
            @(negedge clk);
            start = hammer;
            len = LEN_SZ'($urandom); seed = 8'($urandom); ipg_len = 8'($urandom);
            en_preamble = 1'($urandom); err_en = 1'($urandom); err_idx = LEN_SZ'($urandom);
        end
        cnt_end = frame_cnt;
        frames_done++;
        if (!hold) start = 1'b0;
    endtask

    task automatic test_reset();
        logic [CNT_SZ+11:0] all;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        all = {gmii_data, gmii_dv, gmii_er, busy, done, frame_cnt};
        n_total++;
        if (all !== '0) $display("FAIL reset_held: got %h want 0", all); else n_pass++;
        @(negedge clk) reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            all = {gmii_data, gmii_dv, gmii_er, busy, done, frame_cnt};
            n_total++;
            if (all !== '0) $display("FAIL reset_idle[%0d]: got %h want 0", i, all); else n_pass++;
        end
        frames_done = 0;
    endtask

    task automatic test_known_vector();
        int want[21] = '{'h55, 'h55, 'h55, 'h55, 'h55, 'h55, 'h55, 'hD5,
                         'h31, 'h32, 'h33, 'h34, 'h35, 'h36, 'h37, 'h38, 'h39,
                         'h26, 'h39, 'hF4, 'hCB};
        int bad;
        exp_d.delete(); exp_e.delete();
        foreach (want[i]) begin exp_d.push_back(want[i]); exp_e.push_back(0); end
        run_frame(1, 9, 'h31, 12, 0, 0, 0, 0);
        bad = first_bad();
        n_total++;
        if (bad != -1) $display("FAIL kv_stream: byte %0d got %0d bytes want %0d", bad, cap_d.size(), exp_d.size());
        else n_pass++;
        n_total++;
        if (busy_n !== 33 || !first_busy || timed_out) $display("FAIL kv_busy: got %0d want 33", busy_n); else n_pass++;
        n_total++;
        if (gap_n !== 12 || late_dv !== 0) $display("FAIL kv_gap: got %0d/%0d want 12/0", gap_n, late_dv); else n_pass++;
        n_total++;
        if (done_n !== 1 || done_at !== 33) $display("FAIL kv_done: got %0d@%0d want 1@33", done_n, done_at); else n_pass++;
        n_total++;
        if (cnt_end !== CNT_SZ'(1)) $display("FAIL kv_cnt: got %0d want 1", cnt_end); else n_pass++;
    endtask

    task automatic test_len0();
        model(0, 0, 0, 0, 0);
        run_frame(0, 0, int'($urandom_range(0, 255)), 0, 1, 0, 0, 0);
        n_total++;
        if (first_bad() != -1) $display("FAIL len0_stream: got %0d bytes want 4", cap_d.size()); else n_pass++;
        n_total++;
        if (busy_n !== 5 || done_n !== 1 || done_at !== 5 || gap_n !== 1)
            $display("FAIL len0_timing: got busy %0d done %0d@%0d want 5 1@5", busy_n, done_n, done_at);
        else n_pass++;
        n_total++;
        if (cnt_end !== CNT_SZ'(frames_done)) $display("FAIL len0_cnt: got %0d want %0d", cnt_end, frames_done % 16);
        else n_pass++;
    endtask

    task automatic test_err();
        int bad, ers;
        for (int r = 0; r < 2; r++) begin
            model(0, 4, 'hFE, 1, (r == 0) ? 2 : 4);
            run_frame(0, 4, 'hFE, 3, 1, (r == 0) ? 2 : 4, 0, 0);
            bad = first_bad();
            ers = 0;
            foreach (cap_e[i]) ers += int'(cap_e[i]);
            n_total++;
            if (bad != -1) $display("FAIL err_stream[%0d]: byte %0d", r, bad); else n_pass++;
            n_total++;
            if (ers !== ((r == 0) ? 1 : 0)) $display("FAIL err_count[%0d]: got %0d want %0d", r, ers, (r == 0) ? 1 : 0);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        model(1, 6, 'hA0, 0, 0);
        run_frame(1, 6, 'hA0, 2, 0, 0, 1, 1);
        n_total++;
        if (first_bad() != -1 || done_n !== 1 || busy_n !== 20)
            $display("FAIL b2b_single: got busy %0d done %0d want 20 1", busy_n, done_n);
        else n_pass++;
        model(0, 3, 'h10, 0, 0);
        run_frame(0, 3, 'h10, 1, 0, 0, 0, 0);
        n_total++;
        if (!first_busy) $display("FAIL b2b_accept: got busy %0d want 1", first_busy); else n_pass++;
        n_total++;
        if (first_bad() != -1 || busy_n !== 8) $display("FAIL b2b_second: got busy %0d want 8", busy_n); else n_pass++;
        n_total++;
        if (cnt_end !== CNT_SZ'(frames_done)) $display("FAIL b2b_cnt: got %0d want %0d", cnt_end, frames_done % 16);
        else n_pass++;
    endtask

    task automatic test_random();
        bit pre, een, ham;
        int ln, sd, ipg, eidx, eb, eg, bad;
        for (int f = 0; f < 24; f++) begin
            pre = 1'($urandom); een = 1'($urandom); ham = 1'($urandom);
            ln = (f == 5) ? 300 : int'($urandom_range(0, 40));
            sd = int'($urandom_range(0, 255));
            ipg = int'($urandom_range(0, 20));
            eidx = int'($urandom_range(0, ln + 2));
            eg = (ipg == 0) ? 1 : ipg;
            eb = (pre ? 8 : 0) + ln + 4 + eg;
            model(pre, ln, sd, een, eidx);
            run_frame(pre, ln, sd, ipg, een, eidx, ham, 0);
            bad = first_bad();
            n_total++;
            if (bad != -1) $display("FAIL rnd_stream[%0d]: byte %0d got %0d bytes want %0d", f, bad, cap_d.size(), exp_d.size());
            else n_pass++;
            n_total++;
            if (busy_n !== eb || !first_busy || timed_out) $display("FAIL rnd_busy[%0d]: got %0d want %0d", f, busy_n, eb);
            else n_pass++;
            n_total++;
            if (done_n !== 1 || done_at !== eb) $display("FAIL rnd_done[%0d]: got %0d@%0d want 1@%0d", f, done_n, done_at, eb);
            else n_pass++;
            n_total++;
            if (gap_n !== eg || late_dv !== 0) $display("FAIL rnd_gap[%0d]: got %0d/%0d want %0d/0", f, gap_n, late_dv, eg);
            else n_pass++;
            n_total++;
            if (cnt_end !== CNT_SZ'(frames_done)) $display("FAIL rnd_cnt[%0d]: got %0d want %0d", f, cnt_end, frames_done % 16);
            else n_pass++;
        end
    endtask

    task automatic test_reset_midframe();
        @(negedge clk);
        en_preamble = 1'b1; len = 10; seed = 8'h40; ipg_len = 4; err_en = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        n_total++;
        if (gmii_dv !== 1'b1 || gmii_data !== 8'h42) $display("FAIL mid_pay: got %b/%h want 1/42", gmii_dv, gmii_data);
        else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_total++;
        if (gmii_dv !== 1'b0 || busy !== 1'b0 || gmii_data !== 8'h00 || frame_cnt !== '0)
            $display("FAIL mid_abort: got dv %b busy %b data %h cnt %0d want 0", gmii_dv, busy, gmii_data, frame_cnt);
        else n_pass++;
        frames_done = 0;
        @(negedge clk) reset_n = 1'b1;
        model(1, 5, 'h77, 0, 0);
        run_frame(1, 5, 'h77, 2, 0, 0, 0, 0);
        n_total++;
        if (first_bad() != -1 || busy_n !== 19 || done_n !== 1)
            $display("FAIL mid_restart: got busy %0d done %0d want 19 1", busy_n, done_n);
        else n_pass++;
        n_total++;
        if (cnt_end !== CNT_SZ'(1)) $display("FAIL mid_cnt: got %0d want 1", cnt_end); else n_pass++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        build_table();
        test_reset();
        test_known_vector();
        test_len0();
        test_err();
        test_back_to_back();
        test_random();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
